// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// fixed WIDTH-cycle latency from accepting edge to a one-cycle done pulse.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] Op_A,
   input  logic [WIDTH-1:0] Op_B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e             state_q;
   logic [2:0]         f3_q;
   logic               sa_q, sb_q, bz_q;
   logic [WIDTH-1:0]   a_q, b_q, aorig_q, quo_q, rem_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q, done_q;
   logic [WIDTH-1:0]   result_q;

   logic               a_sgn, b_sgn, sa_in, sb_in;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     msum, rsh, rdiff;
   logic               qbit;
   logic [2*WIDTH-1:0] prod_d, prod_s;
   logic [WIDTH-1:0]   quo_d, rem_d, mul_res, quo_res, rem_res, result_d;

   always_comb begin
      a_sgn = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
      b_sgn = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
      sa_in = a_sgn & Op_A[WIDTH-1];
      sb_in = b_sgn & Op_B[WIDTH-1];
      a_abs = sa_in ? -Op_A : Op_A;
      b_abs = sb_in ? -Op_B : Op_B;
   end

   // Multiplier sits in the low half of the product and is consumed from bit 0.
   always_comb begin
      msum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){prod_q[0]}});
      prod_d = {msum, prod_q[WIDTH-1:1]};
      rsh    = {rem_q, a_q[WIDTH-1]};
      rdiff  = rsh - {1'b0, b_q};
      qbit   = ~rdiff[WIDTH];
      rem_d  = qbit ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], qbit};
   end

   // Final-step result, built from the values the last iteration produces.
   always_comb begin
      prod_s   = (sa_q ^ sb_q) ? -prod_d : prod_d;
      mul_res  = (f3_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
      quo_res  = bz_q ? {WIDTH{1'b1}} : ((sa_q ^ sb_q) ? -quo_d : quo_d);
      rem_res  = bz_q ? aorig_q : (sa_q ? -rem_d : rem_d);
      result_d = !f3_q[2] ? mul_res : (f3_q[1] ? rem_res : quo_res);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         f3_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         bz_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         aorig_q  <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= CALC;
                  busy_q  <= 1'b1;
                  f3_q    <= funct3;
                  sa_q    <= sa_in;
                  sb_q    <= sb_in;
                  bz_q    <= (Op_B == '0);
                  a_q     <= a_abs;
                  b_q     <= b_abs;
                  aorig_q <= Op_A;
                  quo_q   <= '0;
                  rem_q   <= '0;
                  prod_q  <= {{WIDTH{1'b0}}, b_abs};
                  cnt_q   <= '0;
               end
            end
            CALC: begin
               if (f3_q[2]) begin
                  a_q   <= a_q << 1;
                  rem_q <= rem_d;
                  quo_q <= quo_d;
               end else begin
                  prod_q <= prod_d;
               end
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH-1)) begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  result_q <= result_d;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
endmodule
